// File: rtl/wb_arbiter_pkg.sv
// Shared constants for the writeback arbiter: source ordering, widths and
// the demand encoding exchanged between the top and the round-robin selector.
package wb_arbiter_pkg;

    localparam int WB_DATA_W = 64;
    localparam int WB_RN_W   = 6;

    // Fixed source order; the round-robin pointer walks these indices.
    localparam int NSRC  = 5;
    localparam int SRC_W = 3;

    localparam logic [SRC_W-1:0] SRC_ALU1    = 3'd0;
    localparam logic [SRC_W-1:0] SRC_ALU2    = 3'd1;
    localparam logic [SRC_W-1:0] SRC_ADVINT  = 3'd2;
    localparam logic [SRC_W-1:0] SRC_MEMUNIT = 3'd3;
    localparam logic [SRC_W-1:0] SRC_BRANCH  = 3'd4;

    // Register 0 is never written; a zero destination means "no port needed".
    localparam logic [5:0] REG_ZERO = 6'h0;

    // Number of register-file ports a source asks for this cycle.
    typedef enum logic [1:0] {
        DEM_NONE = 2'd0,
        DEM_ONE  = 2'd1,
        DEM_TWO  = 2'd2
    } demand_e;

    // Next source index in rotation, wrapping after the last source.
    function automatic logic [SRC_W-1:0] src_next(input logic [SRC_W-1:0] idx);
        return (idx == SRC_W'(NSRC - 1)) ? SRC_ALU1 : idx + SRC_W'(1);
    endfunction

endpackage

// File: rtl/wb_rr_select.sv
// Combinational round-robin port selector: scans sources from the pointer,
// hands out at most two write ports, never splits a dual-result request.
module wb_rr_select
    import wb_arbiter_pkg::*;
(
    input  logic [2*NSRC-1:0] i_demand,
    input  logic [SRC_W-1:0]  i_ptr,
    output logic [NSRC-1:0]   o_grant,
    output logic              o_p1_vld,
    output logic [SRC_W-1:0]  o_p1_src,
    output logic              o_p2_vld,
    output logic [SRC_W-1:0]  o_p2_src,
    output logic              o_dual_skip
);

    // Walk the rotation once, filling port 1 before port 2.
    always_comb begin
        logic [1:0]       w_free;
        logic [SRC_W-1:0] w_idx;
        logic [1:0]       w_dem;

        o_grant     = '0;
        o_p1_vld    = 1'b0;
        o_p1_src    = SRC_ALU1;
        o_p2_vld    = 1'b0;
        o_p2_src    = SRC_ALU1;
        o_dual_skip = 1'b0;
        w_free      = 2'd2;
        w_idx       = i_ptr;
        w_dem       = DEM_NONE;

        for (int k = 0; k < NSRC; k++) begin
            w_dem = i_demand[2*int'(w_idx) +: 2];
            if (w_dem == DEM_TWO) begin
                // A dual request only goes through with both ports free.
                if (w_free == 2'd2) begin
                    o_grant[w_idx] = 1'b1;
                    o_p1_vld       = 1'b1;
                    o_p1_src       = w_idx;
                    o_p2_vld       = 1'b1;
                    o_p2_src       = w_idx;
                    w_free         = 2'd0;
                end else begin
                    o_dual_skip = 1'b1;
                end
            end else if (w_dem == DEM_ONE) begin
                if (w_free == 2'd2) begin
                    o_grant[w_idx] = 1'b1;
                    o_p1_vld       = 1'b1;
                    o_p1_src       = w_idx;
                    w_free         = 2'd1;
                end else if (w_free == 2'd1) begin
                    o_grant[w_idx] = 1'b1;
                    o_p2_vld       = 1'b1;
                    o_p2_src       = w_idx;
                    w_free         = 2'd0;
                end
            end
            w_idx = src_next(w_idx);
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: collects execution-unit results, grants up to two
// register-file write ports per cycle and registers the write/finished bus.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int DATA_W = WB_DATA_W,
    parameter int RN_W   = WB_RN_W
)(
    input  logic              clk,
    input  logic              rst_n,

    input  logic              alu1_done,
    input  logic [RN_W-1:0]   alu1_rn,
    input  logic [DATA_W-1:0] alu1_data,
    input  logic              alu2_done,
    input  logic [RN_W-1:0]   alu2_rn,
    input  logic [DATA_W-1:0] alu2_data,
    input  logic              advint_done,
    input  logic [RN_W-1:0]   advint_rn,
    input  logic [DATA_W-1:0] advint_data,
    input  logic [RN_W-1:0]   advint_rn2,
    input  logic [DATA_W-1:0] advint_data2,
    input  logic              memunit_done,
    input  logic [RN_W-1:0]   memunit_rn,
    input  logic [DATA_W-1:0] memunit_data,
    input  logic              branch_done,
    input  logic [RN_W-1:0]   branch_rn,
    input  logic [DATA_W-1:0] branch_data,

    output logic              alu1_ack,
    output logic              alu2_ack,
    output logic              advint_ack,
    output logic              memunit_ack,
    output logic              branch_ack,

    output logic              reg1_we,
    output logic [RN_W-1:0]   reg1_finished,
    output logic [DATA_W-1:0] reg1_data,
    output logic              reg2_we,
    output logic [RN_W-1:0]   reg2_finished,
    output logic [DATA_W-1:0] reg2_data
);

    localparam logic [RN_W-1:0] RN_NONE = RN_W'(REG_ZERO);

    logic [NSRC-1:0]   w_done;
    logic [RN_W-1:0]   w_rn   [NSRC];
    logic [DATA_W-1:0] w_data [NSRC];
    logic [2*NSRC-1:0] w_demand;
    logic [NSRC-1:0]   w_zero_ack;
    logic [NSRC-1:0]   w_grant;
    logic [NSRC-1:0]   w_ack;

    logic              w_adv_rn_nz;
    logic              w_adv_rn2_nz;

    logic              w_p1_vld;
    logic [SRC_W-1:0]  w_p1_src;
    logic              w_p2_vld;
    logic [SRC_W-1:0]  w_p2_src;
    logic              w_dual_skip;
    logic              w_p2_dual;

    logic [RN_W-1:0]   w_p1_rn;
    logic [DATA_W-1:0] w_p1_data;
    logic [RN_W-1:0]   w_p2_rn;
    logic [DATA_W-1:0] w_p2_data;

    logic [SRC_W-1:0]  r_ptr;
    logic              r_we1_p1;
    logic [RN_W-1:0]   r_rn1_p1;
    logic [DATA_W-1:0] r_data1_p1;
    logic              r_we2_p1;
    logic [RN_W-1:0]   r_rn2_p1;
    logic [DATA_W-1:0] r_data2_p1;

    assign w_adv_rn_nz  = (advint_rn  != RN_NONE);
    assign w_adv_rn2_nz = (advint_rn2 != RN_NONE);

    // Gather per-source done/destination/data; a single-result advint
    // presents whichever of its two destinations is nonzero.
    always_comb begin
        w_done = '0;
        w_done[SRC_ALU1]    = alu1_done;
        w_done[SRC_ALU2]    = alu2_done;
        w_done[SRC_ADVINT]  = advint_done;
        w_done[SRC_MEMUNIT] = memunit_done;
        w_done[SRC_BRANCH]  = branch_done;

        w_rn[SRC_ALU1]      = alu1_rn;
        w_data[SRC_ALU1]    = alu1_data;
        w_rn[SRC_ALU2]      = alu2_rn;
        w_data[SRC_ALU2]    = alu2_data;
        w_rn[SRC_MEMUNIT]   = memunit_rn;
        w_data[SRC_MEMUNIT] = memunit_data;
        w_rn[SRC_BRANCH]    = branch_rn;
        w_data[SRC_BRANCH]  = branch_data;
        if (w_adv_rn_nz) begin
            w_rn[SRC_ADVINT]   = advint_rn;
            w_data[SRC_ADVINT] = advint_data;
        end else begin
            w_rn[SRC_ADVINT]   = advint_rn2;
            w_data[SRC_ADVINT] = advint_data2;
        end
    end

    // Port demand per source; done sources that write nothing are acked
    // directly without competing for a port.
    always_comb begin
        w_demand   = '0;
        w_zero_ack = '0;
        for (int s = 0; s < NSRC; s++) begin
            if (w_done[s]) begin
                if (s == int'(SRC_ADVINT)) begin
                    if (w_adv_rn_nz && w_adv_rn2_nz) begin
                        w_demand[2*s +: 2] = DEM_TWO;
                    end else if (w_adv_rn_nz || w_adv_rn2_nz) begin
                        w_demand[2*s +: 2] = DEM_ONE;
                    end else begin
                        w_zero_ack[s] = 1'b1;
                    end
                end else if (w_rn[s] != RN_NONE) begin
                    w_demand[2*s +: 2] = DEM_ONE;
                end else begin
                    w_zero_ack[s] = 1'b1;
                end
            end
        end
    end

    wb_rr_select u_select (
        .i_demand    (w_demand),
        .i_ptr       (r_ptr),
        .o_grant     (w_grant),
        .o_p1_vld    (w_p1_vld),
        .o_p1_src    (w_p1_src),
        .o_p2_vld    (w_p2_vld),
        .o_p2_src    (w_p2_src),
        .o_dual_skip (w_dual_skip)
    );

    // Acks are held off entirely while reset is asserted.
    assign w_ack       = rst_n ? (w_grant | w_zero_ack) : '0;
    assign alu1_ack    = w_ack[SRC_ALU1];
    assign alu2_ack    = w_ack[SRC_ALU2];
    assign advint_ack  = w_ack[SRC_ADVINT];
    assign memunit_ack = w_ack[SRC_MEMUNIT];
    assign branch_ack  = w_ack[SRC_BRANCH];

    assign w_p2_dual = w_p1_vld && w_p2_vld &&
                       (w_p1_src == SRC_ADVINT) && (w_p2_src == SRC_ADVINT);

    // Steer the granted results onto the two ports; a dual advint puts
    // its second result on port 2.
    always_comb begin
        w_p1_rn   = w_rn[w_p1_src];
        w_p1_data = w_data[w_p1_src];
        if (w_p2_dual) begin
            w_p2_rn   = advint_rn2;
            w_p2_data = advint_data2;
        end else begin
            w_p2_rn   = w_rn[w_p2_src];
            w_p2_data = w_data[w_p2_src];
        end
    end

    // Rotate the pointer past the last port consumer; a starved dual advint
    // pulls the pointer onto itself so it goes first next cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr <= SRC_ALU1;
        end else if (w_p1_vld) begin
            if (w_dual_skip) begin
                r_ptr <= SRC_ADVINT;
            end else begin
                r_ptr <= src_next(w_p2_vld ? w_p2_src : w_p1_src);
            end
        end
    end

    // Stage p1: register the granted writes for one cycle; idle ports read 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_we1_p1   <= 1'b0;
            r_rn1_p1   <= '0;
            r_data1_p1 <= '0;
            r_we2_p1   <= 1'b0;
            r_rn2_p1   <= '0;
            r_data2_p1 <= '0;
        end else begin
            r_we1_p1   <= w_p1_vld;
            r_rn1_p1   <= w_p1_vld ? w_p1_rn   : '0;
            r_data1_p1 <= w_p1_vld ? w_p1_data : '0;
            r_we2_p1   <= w_p2_vld;
            r_rn2_p1   <= w_p2_vld ? w_p2_rn   : '0;
            r_data2_p1 <= w_p2_vld ? w_p2_data : '0;
        end
    end

    assign reg1_we       = r_we1_p1;
    assign reg1_finished = r_rn1_p1;
    assign reg1_data     = r_data1_p1;
    assign reg2_we       = r_we2_p1;
    assign reg2_finished = r_rn2_p1;
    assign reg2_data     = r_data2_p1;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed scoreboard bench for wb_arbiter: the driver pushes the expected
// register-file write for each cycle, a monitor pops it when a write shows up.
module tb_wb_arbiter;

    localparam int DW = 64;
    localparam int RW = 6;

    logic          clk;
    logic          rst_n;
    logic          alu1_done, alu2_done, advint_done, memunit_done, branch_done;
    logic [RW-1:0] alu1_rn, alu2_rn, advint_rn, advint_rn2, memunit_rn, branch_rn;
    logic [DW-1:0] alu1_data, alu2_data, advint_data, advint_data2, memunit_data, branch_data;
    logic          alu1_ack, alu2_ack, advint_ack, memunit_ack, branch_ack;
    logic          reg1_we, reg2_we;
    logic [RW-1:0] reg1_finished, reg2_finished;
    logic [DW-1:0] reg1_data, reg2_data;

    logic [4:0]    acks;
    assign acks = {branch_ack, memunit_ack, advint_ack, alu2_ack, alu1_ack};

    typedef struct {
        logic          we1;
        logic [RW-1:0] f1;
        logic [DW-1:0] d1;
        logic          we2;
        logic [RW-1:0] f2;
        logic [DW-1:0] d2;
    } exp_t;

    exp_t  sb_q[$];
    string nm_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    bit    mon_en  = 1'b0;

    wb_arbiter dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .alu1_done     (alu1_done),
        .alu1_rn       (alu1_rn),
        .alu1_data     (alu1_data),
        .alu2_done     (alu2_done),
        .alu2_rn       (alu2_rn),
        .alu2_data     (alu2_data),
        .advint_done   (advint_done),
        .advint_rn     (advint_rn),
        .advint_data   (advint_data),
        .advint_rn2    (advint_rn2),
        .advint_data2  (advint_data2),
        .memunit_done  (memunit_done),
        .memunit_rn    (memunit_rn),
        .memunit_data  (memunit_data),
        .branch_done   (branch_done),
        .branch_rn     (branch_rn),
        .branch_data   (branch_data),
        .alu1_ack      (alu1_ack),
        .alu2_ack      (alu2_ack),
        .advint_ack    (advint_ack),
        .memunit_ack   (memunit_ack),
        .branch_ack    (branch_ack),
        .reg1_we       (reg1_we),
        .reg1_finished (reg1_finished),
        .reg1_data     (reg1_data),
        .reg2_we       (reg2_we),
        .reg2_finished (reg2_finished),
        .reg2_data     (reg2_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_srcs();
        alu1_done = 0;    alu1_rn = '0;    alu1_data = '0;
        alu2_done = 0;    alu2_rn = '0;    alu2_data = '0;
        advint_done = 0;  advint_rn = '0;  advint_data = '0;
        advint_rn2 = '0;  advint_data2 = '0;
        memunit_done = 0; memunit_rn = '0; memunit_data = '0;
        branch_done = 0;  branch_rn = '0;  branch_data = '0;
    endtask

    // Inputs are already driven; push the expected write, check acks at the
    // falling edge, then return just after the next rising edge.
    task automatic cyc(input logic [4:0] exp_ack,
                       input logic we1, input logic [RW-1:0] f1, input logic [DW-1:0] d1,
                       input logic we2, input logic [RW-1:0] f2, input logic [DW-1:0] d2,
                       input bit chk_out0, input string nm);
        exp_t e;
        if (we1 || we2) begin
            e = '{we1, f1, d1, we2, f2, d2};
            sb_q.push_back(e);
            nm_q.push_back(nm);
        end
        @(negedge clk);
        n_tests++;
        if (acks !== exp_ack) begin
            n_fail++;
            $display("FAIL %s ack: got %b want %b", nm, acks, exp_ack);
        end
        if (chk_out0) begin
            n_tests++;
            if (reg1_we !== 1'b0 || reg2_we !== 1'b0 ||
                reg1_finished !== '0 || reg2_finished !== '0) begin
                n_fail++;
                $display("FAIL %s out_zero: got we1=%b f1=%0d we2=%b f2=%0d want all 0",
                         nm, reg1_we, reg1_finished, reg2_we, reg2_finished);
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: pop an expectation whenever the DUT presents a write.
    initial begin
        exp_t  e;
        string en;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (reg1_we || reg2_we) begin
                    n_tests++;
                    if (sb_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_write: got we1=%b f1=%0d we2=%b f2=%0d want no write",
                                 reg1_we, reg1_finished, reg2_we, reg2_finished);
                    end else begin
                        e  = sb_q.pop_front();
                        en = nm_q.pop_front();
                        if (reg1_we !== e.we1 || reg1_finished !== e.f1 ||
                            (e.we1 && reg1_data !== e.d1) ||
                            reg2_we !== e.we2 || reg2_finished !== e.f2 ||
                            (e.we2 && reg2_data !== e.d2)) begin
                            n_fail++;
                            $display("FAIL %s write: got we1=%b f1=%0d d1=%h we2=%b f2=%0d d2=%h want we1=%b f1=%0d d1=%h we2=%b f2=%0d d2=%h",
                                     en, reg1_we, reg1_finished, reg1_data, reg2_we, reg2_finished, reg2_data,
                                     e.we1, e.f1, e.d1, e.we2, e.f2, e.d2);
                        end
                    end
                    if (reg1_we && reg2_we) begin
                        n_tests++;
                        if (reg1_finished == reg2_finished && reg1_finished != '0) begin
                            n_fail++;
                            $display("FAIL dup_rn: got both ports rn=%0d want distinct", reg1_finished);
                        end
                    end
                end else begin
                    n_tests++;
                    if (reg1_finished !== '0 || reg2_finished !== '0) begin
                        n_fail++;
                        $display("FAIL idle_finished: got f1=%0d f2=%0d want 0 0",
                                 reg1_finished, reg2_finished);
                    end
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        clear_srcs();
        repeat (2) @(posedge clk);
        mon_en = 1'b1;
        #1;
        cyc(5'b00000, 0, 0, 0, 0, 0, 0, 1, "reset0");
        cyc(5'b00000, 0, 0, 0, 0, 0, 0, 1, "reset1");

        // Release, nothing done
        rst_n = 1'b1;
        repeat (3) cyc(5'b00000, 0, 0, 0, 0, 0, 0, 1, "idle");

        // alu1 alone, ptr 0 -> 1
        alu1_done = 1; alu1_rn = 6'd5; alu1_data = 64'h11;
        cyc(5'b00001, 1, 6'd5, 64'h11, 0, 0, 0, 0, "alu1_alone");

        // ptr 1: alu2 takes port 1, dual advint skipped, ptr -> 2
        clear_srcs();
        alu2_done = 1; alu2_rn = 6'd10; alu2_data = 64'hA2;
        advint_done = 1; advint_rn = 6'd8; advint_data = 64'h88;
        advint_rn2 = 6'd9; advint_data2 = 64'h99;
        cyc(5'b00010, 1, 6'd10, 64'hA2, 0, 0, 0, 0, "adv_skip");

        // ptr 2: dual advint on both ports, ptr -> 3
        alu2_done = 0;
        cyc(5'b00100, 1, 6'd8, 64'h88, 1, 6'd9, 64'h99, 0, "adv_dual");

        // ptr 3: branch port 1, single advint (rn2 only) port 2, ptr -> 3
        clear_srcs();
        branch_done = 1; branch_rn = 6'd13; branch_data = 64'hB3;
        advint_done = 1; advint_rn2 = 6'd12; advint_data2 = 64'hC2;
        cyc(5'b10100, 1, 6'd13, 64'hB3, 1, 6'd12, 64'hC2, 0, "adv_single_rn2");

        // Reset with three sources pending
        clear_srcs();
        rst_n = 1'b0;
        alu1_done = 1;    alu1_rn = 6'd3;    alu1_data = 64'h33;
        alu2_done = 1;    alu2_rn = 6'd4;    alu2_data = 64'h44;
        memunit_done = 1; memunit_rn = 6'd7; memunit_data = 64'h77;
        cyc(5'b00000, 0, 0, 0, 0, 0, 0, 0, "midreset0");
        cyc(5'b00000, 0, 0, 0, 0, 0, 0, 1, "midreset1");
        cyc(5'b00000, 0, 0, 0, 0, 0, 0, 1, "midreset2");

        // Release: ptr 0, alu1/alu2 fill ports, ptr -> 2
        rst_n = 1'b1;
        cyc(5'b00011, 1, 6'd3, 64'h33, 1, 6'd4, 64'h44, 0, "three_c0");
        alu1_done = 0; alu2_done = 0;
        cyc(5'b01000, 1, 6'd7, 64'h77, 0, 0, 0, 0, "three_c1");

        // ptr 4: memunit rn=0 acked without a port, alu1/alu2 fill ports, ptr -> 2
        clear_srcs();
        memunit_done = 1; memunit_rn = 6'd0; memunit_data = 64'hDEAD;
        alu1_done = 1; alu1_rn = 6'd20; alu1_data = 64'h2020;
        alu2_done = 1; alu2_rn = 6'd21; alu2_data = 64'h2121;
        cyc(5'b01011, 1, 6'd20, 64'h2020, 1, 6'd21, 64'h2121, 0, "zero_port_mem");

        // Zero-port branch alone: acked, no write, pointer stays at 2
        clear_srcs();
        branch_done = 1; branch_rn = 6'd0;
        cyc(5'b10000, 0, 0, 0, 0, 0, 0, 0, "zero_port_branch");

        // ptr 2: memunit port 1, alu1 port 2, ptr -> 1
        clear_srcs();
        memunit_done = 1; memunit_rn = 6'd2; memunit_data = 64'h0202;
        alu1_done = 1; alu1_rn = 6'd1; alu1_data = 64'h0101;
        cyc(5'b01001, 1, 6'd2, 64'h0202, 1, 6'd1, 64'h0101, 0, "ptr_hold");

        // ptr 1: alu2 p1, advint skipped, memunit p2, ptr forced to 2
        clear_srcs();
        alu1_done = 1; alu1_rn = 6'd15; alu1_data = 64'h15;
        alu2_done = 1; alu2_rn = 6'd14; alu2_data = 64'h14;
        advint_done = 1; advint_rn = 6'd16; advint_data = 64'h16;
        advint_rn2 = 6'd17; advint_data2 = 64'h17;
        memunit_done = 1; memunit_rn = 6'd18; memunit_data = 64'h18;
        cyc(5'b01010, 1, 6'd14, 64'h14, 1, 6'd18, 64'h18, 0, "skip_force_a");
        alu2_done = 0; memunit_done = 0;
        cyc(5'b00100, 1, 6'd16, 64'h16, 1, 6'd17, 64'h17, 0, "skip_force_b");
        advint_done = 0;
        cyc(5'b00001, 1, 6'd15, 64'h15, 0, 0, 0, 0, "skip_force_c");

        clear_srcs();
        repeat (3) cyc(5'b00000, 0, 0, 0, 0, 0, 0, 0, "tail");

        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending writes want 0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
